rvh_l1d_amo_alu_pipe: RTL and testbench
=======================================

// Module: rvh_l1d_amo_alu_pipe
// PURPOSE
// - Pipelined, parametrised L1D integer/atomic ALU; computes the AMO/LR-SC store value from a fetched line word and the rs2 operand.
// - Sits between the L1D refill/hit data path and the store-merge stage; valid/ready on both sides, in-order, tagged.
// - Adds to the prior combinational ALU: AMO min/max/minu/maxu/swap, XLEN 32 or 64, configurable pipeline depth, backpressure, flush.
// PARAMETERS
// - XLEN    64  datapath width; 32 or 64 only
// - STAGES  2   pipeline registers, issue to wb_vld_o; 1..3
// - TAG_W   4   width of the opaque request tag carried alongside the data
// PORTS
// - clk               in   1        clock, all state on rising edge
// - rst               in   1        asynchronous reset, active-high
// - flush_i           in   1        kill all in-flight ops this cycle
// - issue_vld_i       in   1        request valid
// - issue_rdy_o       out  1        request accepted when vld&rdy
// - issue_opcode_i    in   4        0 ADD,1 SUB,2 SLT,3 SLTU,4 AND,5 OR,6 XOR,7 SLL,8 SRL,9 SRA,10 MIN,11 MAX,12 MINU,13 MAXU,14 SWAP,15 reserved
// - issue_op_w_i      in   1        32-bit word op (XLEN=64 only; ignored at XLEN=32)
// - issue_operand0_i  in   XLEN     memory word / rs1
// - issue_operand1_i  in   XLEN     rs2 / shift amount
// - issue_tag_i       in   TAG_W    request tag
// - wb_vld_o          out  1        result valid
// - wb_rdy_i          in   1        consumer ready
// - wb_data_o         out  XLEN     result
// - wb_tag_o          out  TAG_W    tag of wb_data_o
// - perf_op_cnt_o     out  32       only when RVH_L1D_AMO_ALU_PERF_EN defined
// BEHAVIOUR
// - Reset: all stage valids 0, wb_vld_o=0, wb_data_o=0, wb_tag_o=0, perf_op_cnt_o=0; issue_rdy_o=1 one cycle after rst deasserts.
// - Compute in stage 0 (combinational from inputs); stages 1..STAGES-1 are pure delay registers.
// - Latency: accepted in cycle N -> wb_vld_o in cycle N+STAGES with no backpressure; throughput 1/cycle.
// - Each stage advances when empty or when the next stage advances; last stage advances on wb_rdy_i.
// - issue_rdy_o = ~stage0_vld | stage0_advances; combinational from wb_rdy_i (no skid buffer).
// - wb_vld_o&~wb_rdy_i: wb_data_o, wb_tag_o held stable; no bubble inserted or op dropped.
// - flush_i: all stage valids cleared next cycle; an issue in the same cycle is dropped; flush dominates wb_rdy_i; data regs not cleared.
// - rst mid-operation: in-flight ops lost, outputs return to reset values immediately (async).
// - Arithmetic: ADD/SUB modulo 2^XLEN; SLT/SLTU yield 0/1 zero-extended.
// - MIN/MAX signed compare, MINU/MAXU unsigned; equal operands return operand0; SWAP returns operand1.
// - AND/OR/XOR bitwise; opcode 15 returns 0, no error.
// - Shift amount: operand1[$clog2(XLEN)-1:0]; word ops use operand1[4:0]; SRA sign-fills from bit XLEN-1 (bit 31 for W).
// - op_w: operate on operand[31:0] only (compares sign/zero per op on 32 bits); result bit 31 sign-extended to XLEN for all W ops incl. MINU/MAXU.
// - Logic/SWAP ops with op_w: low 32 bits, sign-extended (AMO*.W semantics).
// CONFIGURATION
// - RVH_L1D_AMO_ALU_PERF_EN defined: 32-bit perf_op_cnt_o counts wb handshakes (wb_vld_o&wb_rdy_i); wraps 0xFFFFFFFF->0; unaffected by flush; cleared by rst.
// - Not defined: port, counter logic absent; all other behaviour identical.
// TESTING
// - XLEN=64,STAGES=2: ADD 0x7FFF_FFFF+1, op_w=1 -> wb_data_o=0xFFFF_FFFF_8000_0000 exactly 2 cycles after accept.
// - MIN a=0xFFFF_FFFF_FFFF_FFFF b=1 -> 0xFFFF_FFFF_FFFF_FFFF; MINU same -> 1; MAXU.W a=0x8000_0000 b=1 -> 0xFFFF_FFFF_8000_0000.
// - SRA.W a=0x8000_0000 amt=0x24 -> 0xFFFF_FFFF_F800_0000; SLL a=1 amt=63 -> 0x8000_0000_0000_0000.
// - Back-to-back 4 ops tags 1..4, wb_rdy_i low 3 cycles then high -> outputs stable while stalled, tags 1..4 in order, none lost.
// - flush_i with 2 ops in flight and issue_vld_i=1 -> wb_vld_o=0 next cycle; next issue returns after exactly STAGES cycles.
// - PERF_EN: 5 handshakes plus 1 flushed op -> perf_op_cnt_o=5; rst asserted mid-stream -> wb_vld_o=0, count=0 immediately.

Source files
------------

// File: rtl/rvh_l1d_amo_alu_pipe.sv
// L1D integer/AMO ALU: computes the store value in stage 0, then delays it through STAGES-1 registers with valid/ready flow.
// Optional: define RVH_L1D_AMO_ALU_PERF_EN to add perf_op_cnt_o, a count of writeback handshakes.
module rvh_l1d_amo_alu_pipe #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              issue_vld_i,
   output logic              issue_rdy_o,
   input  logic [3:0]        issue_opcode_i,
   input  logic              issue_op_w_i,
   input  logic [XLEN-1:0]   issue_operand0_i,
   input  logic [XLEN-1:0]   issue_operand1_i,
   input  logic [TAG_W-1:0]  issue_tag_i,
   output logic              wb_vld_o,
   input  logic              wb_rdy_i,
   output logic [XLEN-1:0]   wb_data_o,
   output logic [TAG_W-1:0]  wb_tag_o
`ifdef RVH_L1D_AMO_ALU_PERF_EN
   ,
   output logic [31:0]       perf_op_cnt_o
`endif
);

   localparam int unsigned SHW = $clog2(XLEN);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLT  = 4'd2,  OP_SLTU = 4'd3,
      OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MIN  = 4'd10, OP_MAX  = 4'd11,
      OP_MINU = 4'd12, OP_MAXU = 4'd13, OP_SWAP = 4'd14, OP_RSVD = 4'd15
   } op_e;

   op_e             op;
   logic            use_w;
   logic [XLEN-1:0] a, b, res_x, res;
   logic [31:0]     a_w, b_w, res_w;
   logic [SHW-1:0]  shamt;
   logic [4:0]      shamt_w;
   logic            lt_s, lt_u, lt_s_w, lt_u_w;

   always_comb begin
      op      = op_e'(issue_opcode_i);
      use_w   = issue_op_w_i && (XLEN == 64);
      a       = issue_operand0_i;
      b       = issue_operand1_i;
      a_w     = a[31:0];
      b_w     = b[31:0];
      shamt   = b[SHW-1:0];
      shamt_w = b[4:0];
      lt_s    = $signed(a) < $signed(b);
      lt_u    = a < b;
      lt_s_w  = $signed(a_w) < $signed(b_w);
      lt_u_w  = a_w < b_w;

      res_x = '0;
      case (op)
         OP_ADD:  res_x = a + b;
         OP_SUB:  res_x = a - b;
         OP_SLT:  res_x = {{(XLEN-1){1'b0}}, lt_s};
         OP_SLTU: res_x = {{(XLEN-1){1'b0}}, lt_u};
         OP_AND:  res_x = a & b;
         OP_OR:   res_x = a | b;
         OP_XOR:  res_x = a ^ b;
         OP_SLL:  res_x = a << shamt;
         OP_SRL:  res_x = a >> shamt;
         OP_SRA:  res_x = $unsigned($signed(a) >>> shamt);
         OP_MIN:  res_x = lt_s ? a : b;
         OP_MAX:  res_x = lt_s ? b : a;
         OP_MINU: res_x = lt_u ? a : b;
         OP_MAXU: res_x = lt_u ? b : a;
         OP_SWAP: res_x = b;
         default: res_x = '0;
      endcase

      res_w = '0;
      case (op)
         OP_ADD:  res_w = a_w + b_w;
         OP_SUB:  res_w = a_w - b_w;
         OP_SLT:  res_w = {31'd0, lt_s_w};
         OP_SLTU: res_w = {31'd0, lt_u_w};
         OP_AND:  res_w = a_w & b_w;
         OP_OR:   res_w = a_w | b_w;
         OP_XOR:  res_w = a_w ^ b_w;
         OP_SLL:  res_w = a_w << shamt_w;
         OP_SRL:  res_w = a_w >> shamt_w;
         OP_SRA:  res_w = $unsigned($signed(a_w) >>> shamt_w);
         OP_MIN:  res_w = lt_s_w ? a_w : b_w;
         OP_MAX:  res_w = lt_s_w ? b_w : a_w;
         OP_MINU: res_w = lt_u_w ? a_w : b_w;
         OP_MAXU: res_w = lt_u_w ? b_w : a_w;
         OP_SWAP: res_w = b_w;
         default: res_w = '0;
      endcase

      // Every W op, unsigned compares included, sign-extends bit 31.
      res = use_w ? XLEN'($signed(res_w)) : res_x;
   end

   logic [STAGES-1:0] vld_q, vld_d, adv;
   logic [XLEN-1:0]   data_q [STAGES];
   logic [XLEN-1:0]   data_d [STAGES];
   logic [TAG_W-1:0]  tag_q  [STAGES];
   logic [TAG_W-1:0]  tag_d  [STAGES];

   // Ready ripples back from the consumer; a local carry avoids a self-referencing vector.
   always_comb begin
      logic chain;
      chain = wb_rdy_i;
      adv   = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         adv[STAGES-1-k] = ~vld_q[STAGES-1-k] | chain;
         chain           = adv[STAGES-1-k];
      end
   end

   always_comb begin
      issue_rdy_o = adv[0];
      vld_d       = vld_q;
      for (int unsigned i = 0; i < STAGES; i++) begin
         data_d[i] = data_q[i];
         tag_d[i]  = tag_q[i];
      end

      if (adv[0]) begin
         vld_d[0] = issue_vld_i;
         if (issue_vld_i) begin
            data_d[0] = res;
            tag_d[0]  = issue_tag_i;
         end
      end

      for (int unsigned i = 1; i < STAGES; i++) begin
         if (adv[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
               data_d[i] = data_q[i-1];
               tag_d[i]  = tag_q[i-1];
            end
         end
      end

      if (flush_i) vld_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int unsigned i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

   assign wb_vld_o  = vld_q[STAGES-1];
   assign wb_data_o = data_q[STAGES-1];
   assign wb_tag_o  = tag_q[STAGES-1];

`ifdef RVH_L1D_AMO_ALU_PERF_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;

   always_comb begin
      perf_cnt_d = perf_cnt_q + ((wb_vld_o && wb_rdy_i) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) perf_cnt_q <= '0;
      else     perf_cnt_q <= perf_cnt_d;
   end

   assign perf_op_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_rvh_l1d_amo_alu_pipe.sv
// Scoreboard bench for rvh_l1d_amo_alu_pipe (XLEN=64, STAGES=2); perf checks only with RVH_L1D_AMO_ALU_PERF_EN.
module tb_rvh_l1d_amo_alu_pipe;

   localparam int XLEN   = 64;
   localparam int STAGES = 2;
   localparam int TAG_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush_i;
   logic              issue_vld_i;
   logic              issue_rdy_o;
   logic [3:0]        issue_opcode_i;
   logic              issue_op_w_i;
   logic [XLEN-1:0]   issue_operand0_i;
   logic [XLEN-1:0]   issue_operand1_i;
   logic [TAG_W-1:0]  issue_tag_i;
   logic              wb_vld_o;
   logic              wb_rdy_i;
   logic [XLEN-1:0]   wb_data_o;
   logic [TAG_W-1:0]  wb_tag_o;
`ifdef RVH_L1D_AMO_ALU_PERF_EN
   logic [31:0]       perf_op_cnt_o;
`endif

   rvh_l1d_amo_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .issue_vld_i      (issue_vld_i),
      .issue_rdy_o      (issue_rdy_o),
      .issue_opcode_i   (issue_opcode_i),
      .issue_op_w_i     (issue_op_w_i),
      .issue_operand0_i (issue_operand0_i),
      .issue_operand1_i (issue_operand1_i),
      .issue_tag_i      (issue_tag_i),
      .wb_vld_o         (wb_vld_o),
      .wb_rdy_i         (wb_rdy_i),
      .wb_data_o        (wb_data_o),
      .wb_tag_o         (wb_tag_o)
`ifdef RVH_L1D_AMO_ALU_PERF_EN
      ,
      .perf_op_cnt_o    (perf_op_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] e;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  tag;
      int          acc;
   } exp_t;

   localparam int NV = 27;
   vec_t vecs [NV] = '{
      '{4'd0,  1'b1, 64'h7FFF_FFFF,           64'h1,                   64'hFFFF_FFFF_8000_0000},
      '{4'd10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'hFFFF_FFFF_FFFF_FFFF},
      '{4'd12, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1},
      '{4'd13, 1'b1, 64'h8000_0000,           64'h1,                   64'hFFFF_FFFF_8000_0000},
      '{4'd9,  1'b1, 64'h8000_0000,           64'h24,                  64'hFFFF_FFFF_F800_0000},
      '{4'd7,  1'b0, 64'h1,                   64'd63,                  64'h8000_0000_0000_0000},
      '{4'd1,  1'b0, 64'h0,                   64'h1,                   64'hFFFF_FFFF_FFFF_FFFF},
      '{4'd2,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1},
      '{4'd3,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0},
      '{4'd4,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000},
      '{4'd5,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0},
      '{4'd6,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0},
      '{4'd8,  1'b0, 64'h8000_0000_0000_0000, 64'h41,                  64'h4000_0000_0000_0000},
      '{4'd9,  1'b0, 64'h8000_0000_0000_0000, 64'h4,                   64'hF800_0000_0000_0000},
      '{4'd11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1},
      '{4'd14, 1'b0, 64'h5,                   64'hDEAD,                64'hDEAD},
      '{4'd14, 1'b1, 64'h0,                   64'h1_8000_0000,         64'hFFFF_FFFF_8000_0000},
      '{4'd15, 1'b0, 64'h123,                 64'h456,                 64'h0},
      '{4'd12, 1'b1, 64'h1_0000_0005,         64'h2_0000_0006,         64'h5},
      '{4'd4,  1'b1, 64'hFFFF_FFFF_8000_0001, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001},
      '{4'd7,  1'b1, 64'h1,                   64'd31,                  64'hFFFF_FFFF_8000_0000},
      '{4'd3,  1'b1, 64'h1_0000_0000,         64'h1,                   64'h1},
      '{4'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   64'h1},
      '{4'd10, 1'b1, 64'h8000_0000,           64'h7FFF_FFFF,           64'hFFFF_FFFF_8000_0000},
      '{4'd13, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
      '{4'd8,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1,                   64'h4000_0000},
      '{4'd10, 1'b0, 64'h7,                   64'h7,                   64'h7}
   };

   exp_t        sb [$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic        hs_issue, hs_wb, s_vld, s_rdy;
   logic [63:0] s_data;
   logic [3:0]  s_tag;
   int          s_cyc;

   // Snapshot everything mid-cycle, then move to just after the next rising edge.
   task automatic step();
      @(negedge clk);
      hs_issue = issue_vld_i & issue_rdy_o;
      hs_wb    = wb_vld_o & wb_rdy_i;
      s_vld    = wb_vld_o;
      s_rdy    = issue_rdy_o;
      s_data   = wb_data_o;
      s_tag    = wb_tag_o;
      s_cyc    = cyc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic [3:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] tag);
      issue_vld_i      = 1'b1;
      issue_opcode_i   = op;
      issue_op_w_i     = w;
      issue_operand0_i = a;
      issue_operand1_i = b;
      issue_tag_i      = tag;
   endtask

   task automatic idle();
      issue_vld_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush_i = 1'b0; wb_rdy_i = 1'b1;
      issue_vld_i = 1'b0; issue_opcode_i = '0; issue_op_w_i = 1'b0;
      issue_operand0_i = '0; issue_operand1_i = '0; issue_tag_i = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec += 3;
      if (wb_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b expected 0", wb_vld_o); end
      if (wb_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", wb_data_o); end
      if (wb_tag_o !== '0) begin n_err++; $display("FAIL reset_tag: got %h expected 0", wb_tag_o); end
      rst = 1'b0;
      step();
      n_vec++;
      if (s_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b expected 1", s_rdy); end
   endtask

   task automatic test_ops();
      int   i = 0;
      int   got = 0;
      exp_t e;
      wb_rdy_i = 1'b1;
      for (int budget = 0; budget < 200 && got < NV; budget++) begin
         if (i < NV) drive(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 4'(i));
         else        idle();
         step();
         if (hs_issue) begin
            sb.push_back('{vecs[i].e, 4'(i), s_cyc});
            i++;
         end
         if (hs_wb) begin
            got++;
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL ops_spurious: got tag %h expected no output", s_tag);
            end else begin
               e = sb.pop_front();
               n_vec += 3;
               if (s_data !== e.data) begin n_err++; $display("FAIL ops_data[%0d]: got %h expected %h", e.tag, s_data, e.data); end
               if (s_tag !== e.tag) begin n_err++; $display("FAIL ops_tag: got %h expected %h", s_tag, e.tag); end
               if (s_cyc - e.acc != STAGES) begin n_err++; $display("FAIL ops_latency[%0d]: got %0d expected %0d", e.tag, s_cyc - e.acc, STAGES); end
            end
         end
      end
      idle();
      if (got < NV) begin n_vec++; n_err++; $display("FAIL ops_timeout: got %0d results expected %0d", got, NV); end
   endtask

   task automatic test_back_to_back();
      int          i = 0;
      int          got = 0;
      int          stall_cnt = 0;
      logic [63:0] ref_data;
      logic [3:0]  ref_tag;
      exp_t        e;
      for (int budget = 0; budget < 40 && got < 4; budget++) begin
         wb_rdy_i = (stall_cnt >= 3);
         if (i < 4) drive(4'd0, 1'b0, 64'h100 * (i + 1), 64'(i + 1), 4'(i + 1));
         else       idle();
         step();
         if (hs_issue) begin
            sb.push_back('{64'h101 * (i + 1), 4'(i + 1), s_cyc});
            i++;
         end
         if (s_vld && !hs_wb) begin
            if (stall_cnt == 0) begin
               ref_data = s_data;
               ref_tag  = s_tag;
            end else begin
               n_vec += 2;
               if (s_data !== ref_data) begin n_err++; $display("FAIL b2b_hold_data: got %h expected %h", s_data, ref_data); end
               if (s_tag !== ref_tag) begin n_err++; $display("FAIL b2b_hold_tag: got %h expected %h", s_tag, ref_tag); end
            end
            n_vec++;
            if (s_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_full_rdy: got %b expected 0", s_rdy); end
            stall_cnt++;
         end
         if (hs_wb) begin
            got++;
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL b2b_spurious: got tag %h expected no output", s_tag);
            end else begin
               e = sb.pop_front();
               n_vec += 2;
               if (s_data !== e.data) begin n_err++; $display("FAIL b2b_data: got %h expected %h", s_data, e.data); end
               if (s_tag !== e.tag) begin n_err++; $display("FAIL b2b_tag: got %h expected %h", s_tag, e.tag); end
            end
         end
      end
      idle();
      wb_rdy_i = 1'b1;
      n_vec += 2;
      if (got != 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", got); end
      if (stall_cnt != 3) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stall_cnt); end
   endtask

   task automatic test_flush();
      int   got = 0;
      exp_t e;
      // Two ops held in the pipe, flushed while a third is offered.
      wb_rdy_i = 1'b0;
      drive(4'd0, 1'b0, 64'h10, 64'h1, 4'd5);
      step();
      drive(4'd0, 1'b0, 64'h20, 64'h1, 4'd6);
      step();
      drive(4'd0, 1'b0, 64'h30, 64'h1, 4'd7);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      idle();
      wb_rdy_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_vec++;
         if (s_vld !== 1'b0) begin n_err++; $display("FAIL flush_vld[%0d]: got %b expected 0", k, s_vld); end
      end
      // Issue offered in the flush cycle on an empty pipe must vanish.
      drive(4'd0, 1'b0, 64'h40, 64'h1, 4'd8);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         n_vec++;
         if (s_vld !== 1'b0) begin n_err++; $display("FAIL flush_drop[%0d]: got %b expected 0", k, s_vld); end
      end
      drive(4'd1, 1'b0, 64'd10, 64'd3, 4'd9);
      for (int budget = 0; budget < 10 && got < 1; budget++) begin
         step();
         if (hs_issue) sb.push_back('{64'd7, 4'd9, s_cyc});
         idle();
         if (hs_wb) begin
            got++;
            e = sb.pop_front();
            n_vec += 3;
            if (s_data !== e.data) begin n_err++; $display("FAIL flush_next_data: got %h expected %h", s_data, e.data); end
            if (s_tag !== e.tag) begin n_err++; $display("FAIL flush_next_tag: got %h expected %h", s_tag, e.tag); end
            if (s_cyc - e.acc != STAGES) begin n_err++; $display("FAIL flush_next_latency: got %0d expected %0d", s_cyc - e.acc, STAGES); end
         end
      end
      if (got != 1) begin n_vec++; n_err++; $display("FAIL flush_next_timeout: got %0d results expected 1", got); end
   endtask

`ifdef RVH_L1D_AMO_ALU_PERF_EN
   task automatic test_perf();
      int   i = 0;
      int   got = 0;
      exp_t e;
      rst = 1'b1;
      #1;
      n_vec++;
      if (perf_op_cnt_o !== 32'd0) begin n_err++; $display("FAIL perf_reset: got %0d expected 0", perf_op_cnt_o); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_rdy_i = 1'b1;
      for (int budget = 0; budget < 30 && got < 5; budget++) begin
         if (i < 5) drive(4'd6, 1'b0, 64'hA5, 64'(i), 4'(i));
         else       idle();
         step();
         if (hs_issue) begin
            sb.push_back('{64'hA5 ^ 64'(i), 4'(i), s_cyc});
            i++;
         end
         if (hs_wb) begin
            got++;
            e = sb.pop_front();
            n_vec++;
            if (s_data !== e.data) begin n_err++; $display("FAIL perf_data: got %h expected %h", s_data, e.data); end
         end
      end
      drive(4'd0, 1'b0, 64'h1, 64'h1, 4'hF);
      step();
      idle();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      repeat (4) step();
      n_vec += 2;
      if (got != 5) begin n_err++; $display("FAIL perf_handshakes: got %0d expected 5", got); end
      if (perf_op_cnt_o !== 32'd5) begin n_err++; $display("FAIL perf_count: got %0d expected 5", perf_op_cnt_o); end
   endtask
`endif

   task automatic test_reset_mid();
      wb_rdy_i = 1'b1;
      drive(4'd0, 1'b0, 64'h1234, 64'h1, 4'hA);
      step();
      drive(4'd0, 1'b0, 64'h5678, 64'h1, 4'hB);
      step();
      idle();
      n_vec++;
      if (wb_vld_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_vld: got %b expected 1", wb_vld_o); end
      #2;
      rst = 1'b1;
      #1;
      n_vec += 3;
      if (wb_vld_o !== 1'b0) begin n_err++; $display("FAIL rstmid_vld: got %b expected 0", wb_vld_o); end
      if (wb_data_o !== '0) begin n_err++; $display("FAIL rstmid_data: got %h expected 0", wb_data_o); end
      if (wb_tag_o !== '0) begin n_err++; $display("FAIL rstmid_tag: got %h expected 0", wb_tag_o); end
`ifdef RVH_L1D_AMO_ALU_PERF_EN
      n_vec++;
      if (perf_op_cnt_o !== 32'd0) begin n_err++; $display("FAIL rstmid_perf: got %0d expected 0", perf_op_cnt_o); end
`endif
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      n_vec += 2;
      if (s_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_post_vld: got %b expected 0", s_vld); end
      if (s_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_post_rdy: got %b expected 1", s_rdy); end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      sb.delete();
      test_flush();
`ifdef RVH_L1D_AMO_ALU_PERF_EN
      test_perf();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
